// File: rtl/st_order_scheduler.sv
// st_order_scheduler: round-robin packet order-token generator; define ST_ORDER_SCHED_WEIGHT_EN for per-requester burst weights.
module st_order_scheduler #(
  parameter int NB_IN = 4,
  parameter int BEATS_W = 8,
  localparam int IW = $clog2(NB_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NB_IN-1:0]         desc_valid,
  output logic [NB_IN-1:0]         desc_ready,
  input  logic [NB_IN*BEATS_W-1:0] desc_beats,
`ifdef ST_ORDER_SCHED_WEIGHT_EN
  input  logic [NB_IN*4-1:0]       weight,
`endif
  output logic                     order_valid,
  input  logic                     order_ready,
  output logic [IW-1:0]            order_data,
  output logic                     busy
);
  if (NB_IN < 2 || (NB_IN & (NB_IN - 1)) != 0) begin : g_bad_nb_in
    $error("NB_IN must be a power of two");
  end
  typedef enum logic {IDLE, EMIT} state_t;
  state_t r_state, w_state_nx;
  logic [NB_IN-1:0]   r_held, w_acc, w_avail;
  logic [BEATS_W-1:0] r_beats [NB_IN];
  logic [BEATS_W-1:0] w_in_beats [NB_IN];
  logic [BEATS_W-1:0] r_cnt;
  logic [IW-1:0]      r_grant, r_last, w_rr, w_pick;
  logic               w_any, w_hs, w_last_beat;
  always_comb begin
    for (int i = 0; i < NB_IN; i++) begin
      w_in_beats[i] = desc_beats[i*BEATS_W +: BEATS_W];
      w_acc[i] = desc_valid[i] & ~r_held[i] & (w_in_beats[i] != '0);
    end
  end
  always_comb begin
    w_rr = r_last;
    for (int k = NB_IN; k >= 1; k--)
      if (w_avail[IW'(r_last + IW'(k))]) w_rr = IW'(r_last + IW'(k));
  end
`ifdef ST_ORDER_SCHED_WEIGHT_EN
  // A descriptor accepted in the bubble cycle counts as available, so a
  // continuously refilled requester can be re-granted back to back.
  logic [3:0] r_burst, w_wt;
  logic       w_regrant;
  assign w_avail = r_held | w_acc;
  always_comb begin
    w_wt = weight[{r_last, 2'b00} +: 4];
    w_regrant = w_avail[r_last] && (r_burst < ((w_wt == 4'd0) ? 4'd1 : w_wt));
    w_pick = w_regrant ? r_last : w_rr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_burst <= 4'd0;
    else if (r_state == IDLE && w_any) r_burst <= w_regrant ? r_burst + 4'd1 : 4'd1;
  end
`else
  assign w_avail = r_held;
  assign w_pick = w_rr;
`endif
  assign w_any = |w_avail;
  assign w_hs = (r_state == EMIT) && order_ready;
  assign w_last_beat = w_hs && (r_cnt == BEATS_W'(1));
  always_comb begin
    w_state_nx = r_state;
    if (r_state == IDLE && w_any) w_state_nx = EMIT;
    if (w_last_beat) w_state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_held <= '0;
      r_cnt <= '0;
      r_grant <= '0;
      r_last <= IW'(NB_IN - 1);
      for (int i = 0; i < NB_IN; i++) r_beats[i] <= '0;
    end else begin
      r_state <= w_state_nx;
      for (int i = 0; i < NB_IN; i++) if (w_acc[i]) r_beats[i] <= w_in_beats[i];
      r_held <= (r_held | w_acc) & ~(w_last_beat ? (NB_IN'(1) << r_grant) : '0);
      if (r_state == IDLE && w_any) begin
        r_grant <= w_pick;
        r_cnt <= r_held[w_pick] ? r_beats[w_pick] : w_in_beats[w_pick];
      end else if (w_hs) r_cnt <= r_cnt - BEATS_W'(1);
      if (w_last_beat) r_last <= r_grant;
    end
  end
  assign desc_ready = ~r_held;
  assign order_valid = (r_state == EMIT);
  assign order_data = r_grant;
  assign busy = order_valid | (|r_held);
endmodule

// File: tb/tb_st_order_scheduler.sv
// tb_st_order_scheduler: directed checks of ordering, stalls, zero-beat drops and reset abort.
module tb_st_order_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  desc_valid = '0;
  logic [3:0]  desc_ready;
  logic [31:0] desc_beats = '0;
  logic        order_valid;
  logic        order_ready = 1'b0;
  logic [1:0]  order_data;
  logic        busy;
`ifdef ST_ORDER_SCHED_WEIGHT_EN
  logic [15:0] weight = 16'h0002;
`endif
  int n_chk = 0;
  int n_pass = 0;
  int tok;
  always #5 clk = ~clk;
  st_order_scheduler #(.NB_IN(4), .BEATS_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_beats(desc_beats),
`ifdef ST_ORDER_SCHED_WEIGHT_EN
    .weight(weight),
`endif
    .order_valid(order_valid), .order_ready(order_ready),
    .order_data(order_data), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic set_desc(input int i, input int b);
    desc_valid[i] = 1'b1;
    desc_beats[i*8 +: 8] = 8'(b);
  endtask
  initial begin
`ifdef ST_ORDER_SCHED_WEIGHT_EN
    int exp_w [6] = '{0, 0, 1, 0, 0, 1};
`else
    int t1_v [7] = '{1, 1, 1, 0, 1, 1, 0};
    int t1_d [7] = '{0, 0, 0, 0, 2, 2, 0};
`endif
    step();
    step();
    chk("rst_valid", 32'(order_valid), 0);
    chk("rst_data", 32'(order_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(desc_ready), 4'hF);
    rst_n = 1'b1;
    step();
    chk("idle_valid", 32'(order_valid), 0);
`ifdef ST_ORDER_SCHED_WEIGHT_EN
    order_ready = 1'b1;
    set_desc(0, 1);
    set_desc(1, 1);
    for (int j = 0; j < 12; j++) begin
      step();
      if (j % 2 == 0) begin
        chk("w_valid", 32'(order_valid), 1);
        chk("w_data", 32'(order_data), 32'(exp_w[j/2]));
      end else chk("w_bubble", 32'(order_valid), 0);
    end
    desc_valid = '0;
`else
    order_ready = 1'b1;
    set_desc(0, 3);
    set_desc(2, 2);
    step();
    desc_valid = '0;
    chk("t1_ready", 32'(desc_ready), 4'b1010);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_wait", 32'(order_valid), 0);
    for (int j = 0; j < 7; j++) begin
      step();
      chk("t1_valid", 32'(order_valid), 32'(t1_v[j]));
      if (t1_v[j] == 1) chk("t1_data", 32'(order_data), 32'(t1_d[j]));
    end
    chk("t1_done_busy", 32'(busy), 0);
    chk("t1_done_ready", 32'(desc_ready), 4'hF);
    order_ready = 1'b0;
    set_desc(1, 4);
    step();
    desc_valid = '0;
    chk("t2_wait", 32'(order_valid), 0);
    tok = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t2_valid", 32'(order_valid), 32'(tok < 4));
      if (order_valid) chk("t2_data", 32'(order_data), 1);
      order_ready = i[0];
      if (order_valid && order_ready) tok++;
    end
    chk("t2_tokens", 32'(tok), 4);
    order_ready = 1'b1;
    set_desc(3, 0);
    step();
    desc_valid = '0;
    chk("t4_ready", 32'(desc_ready), 4'hF);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_valid", 32'(order_valid), 0);
    step();
    chk("t4_busy2", 32'(busy), 0);
    chk("t4_valid2", 32'(order_valid), 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_desc(i, 1);
    step();
    chk("t3_wait", 32'(order_valid), 0);
    for (int j = 0; j < 10; j++) begin
      step();
      if (j % 2 == 0) begin
        chk("t3_valid", 32'(order_valid), 1);
        chk("t3_data", 32'(order_data), 32'((j / 2) % 4));
      end else chk("t3_bubble", 32'(order_valid), 0);
    end
    desc_valid = '0;
    repeat (10) step();
    chk("t3_drained", 32'(busy), 0);
    set_desc(2, 5);
    step();
    desc_valid = '0;
    chk("t5_wait", 32'(order_valid), 0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t5_valid", 32'(order_valid), 1);
      chk("t5_data", 32'(order_data), 2);
    end
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(order_valid), 0);
    chk("t5_rst_data", 32'(order_data), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_ready", 32'(desc_ready), 4'hF);
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("t5_no_tokens", 32'(order_valid), 0);
    end
    chk("t5_ready_after", 32'(desc_ready), 4'hF);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
